pipe_ctrl: RTL and testbench

Central hazard and sequencing controller for the five-stage pipeline. Generates per-stage stall (hold) and flush (bubble) controls for regD, regE, regM and regW and the fetch PC register. Handles load-use hazards, execute-stage redirects, data-memory wait states, a memory-timeout watchdog and halt-on-ebreak. Sits beside the pipeline registers; every pipeline register consumes its stall/flush pair at the next rising edge.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_det.sv | 32 +++
 rtl/pipe_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Brief    : Shared types and constants for the pipeline hazard controller.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } pipe_state_e;

  // Architectural zero register never creates a dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Per-stage hold / bubble pair
  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_if
//  Brief    : Hazard inputs and per-stage stall/flush controls between the
//             pipeline datapath (master) and the controller (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
  logic [4:0] d_i_rs1;
  logic [4:0] d_i_rs2;
  logic       d_i_rs1_used;
  logic       d_i_rs2_used;
  logic [4:0] e_i_rd;
  logic       e_i_rd_wen;
  logic       e_i_is_load;
  logic       e_i_redirect;
  logic       m_i_req;
  logic       m_i_ready;
  logic       w_i_halt;
  logic       f_o_stall;
  logic       d_o_stall;
  logic       e_o_stall;
  logic       m_o_stall;
  logic       d_o_flush;
  logic       e_o_flush;
  logic       w_o_flush;

  modport master (
    output d_i_rs1, d_i_rs2, d_i_rs1_used, d_i_rs2_used, e_i_rd, e_i_rd_wen,
           e_i_is_load, e_i_redirect, m_i_req, m_i_ready, w_i_halt,
    input  f_o_stall, d_o_stall, e_o_stall, m_o_stall, d_o_flush, e_o_flush,
           w_o_flush
  );

  modport slave (
    input  d_i_rs1, d_i_rs2, d_i_rs1_used, d_i_rs2_used, e_i_rd, e_i_rd_wen,
           e_i_is_load, e_i_redirect, m_i_req, m_i_ready, w_i_halt,
    output f_o_stall, d_o_stall, e_o_stall, m_o_stall, d_o_flush, e_o_flush,
           w_o_flush
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_det.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_det
//  Brief    : Combinational load-use comparator between regD sources and the
//             regE load destination.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_det
  import pipe_pkg::*;
(
  input  wire logic [4:0] i_rs1,
  input  wire logic [4:0] i_rs2,
  input  wire logic       i_rs1_used,
  input  wire logic       i_rs2_used,
  input  wire logic [4:0] i_rd,
  input  wire logic       i_rd_wen,
  input  wire logic       i_is_load,
  output logic            o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  // A load whose result a regD source needs before it leaves memory
  always_comb begin
    w_rs1_hit  = i_rs1_used && (i_rs1 == i_rd);
    w_rs2_hit  = i_rs2_used && (i_rs2 == i_rd);
    o_load_use = i_is_load && i_rd_wen && (i_rd != REG_ZERO) && (w_rs1_hit || w_rs2_hit);
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Brief    : Five-stage pipeline hazard/sequencing controller: load-use
//             bubbles, redirect squash, memory wait, timeout watchdog, halt.
//             Optional performance counters under PIPE_CTRL_PERF_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 1023
) (
  input  wire logic   clk,
  input  wire logic   rst,
  pipe_ctrl_if.slave  pif,
  output logic        o_halted,
  output logic        o_mem_timeout,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt,
  output logic [31:0] o_lu_cnt
);

  localparam logic [15:0] C_TIMEOUT = 16'(MEM_TIMEOUT);

  pipe_state_e state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        tmo_q, tmo_d;
  logic        w_load_use;
  logic        w_resolve;
  logic        w_freeze;
  logic        w_redir_take;
  logic        w_lu_take;
  stage_ctrl_t w_d_ctl;
  stage_ctrl_t w_e_ctl;

  pipe_hazard_det u_hazard (
    .i_rs1      (pif.d_i_rs1),
    .i_rs2      (pif.d_i_rs2),
    .i_rs1_used (pif.d_i_rs1_used),
    .i_rs2_used (pif.d_i_rs2_used),
    .i_rd       (pif.e_i_rd),
    .i_rd_wen   (pif.e_i_rd_wen),
    .i_is_load  (pif.e_i_is_load),
    .o_load_use (w_load_use)
  );

  // Next-state, watchdog and per-stage control decode
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    tmo_d        = tmo_q;
    w_resolve    = 1'b0;
    w_freeze     = 1'b0;
    w_redir_take = 1'b0;
    w_lu_take    = 1'b0;
    w_d_ctl      = '0;
    w_e_ctl      = '0;

    unique case (state_q)
      RUN: begin
        if (pif.w_i_halt) begin
          w_freeze = 1'b1;
          state_d  = HALT;
        end else if (pif.m_i_req && !pif.m_i_ready) begin
          w_freeze = 1'b1;
          wcnt_d   = 16'd0;
          state_d  = MEM_WAIT;
        end else begin
          w_resolve = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (pif.w_i_halt) begin
          w_freeze = 1'b1;
          state_d  = HALT;
        end else if (pif.m_i_ready) begin
          w_resolve = 1'b1;
          state_d   = RUN;
        end else begin
          w_freeze = 1'b1;
          if (wcnt_q == C_TIMEOUT) begin
            tmo_d   = 1'b1;
            state_d = HALT;
          end else begin
            wcnt_d = wcnt_q + 16'd1;
          end
        end
      end
      HALT: begin
        w_freeze = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Redirect outranks load-use: the regD instruction is on the wrong path
    if (w_resolve) begin
      if (pif.e_i_redirect) begin
        w_redir_take  = 1'b1;
        w_d_ctl.flush = 1'b1;
        w_e_ctl.flush = 1'b1;
      end else if (w_load_use) begin
        w_lu_take     = 1'b1;
        w_d_ctl.stall = 1'b1;
        w_e_ctl.flush = 1'b1;
      end
    end

    if (w_freeze) begin
      w_d_ctl.stall = 1'b1;
      w_e_ctl.stall = 1'b1;
    end

    pif.f_o_stall = w_freeze || w_lu_take;
    pif.d_o_stall = w_d_ctl.stall;
    pif.e_o_stall = w_e_ctl.stall;
    pif.m_o_stall = w_freeze;
    pif.d_o_flush = w_d_ctl.flush;
    pif.e_o_flush = w_e_ctl.flush;
    pif.w_o_flush = w_freeze;
    o_halted      = (state_q == HALT);

    // Reset empties the pipeline with bubbles and holds nothing
    if (rst) begin
      pif.f_o_stall = 1'b0;
      pif.d_o_stall = 1'b0;
      pif.e_o_stall = 1'b0;
      pif.m_o_stall = 1'b0;
      pif.d_o_flush = 1'b1;
      pif.e_o_flush = 1'b1;
      pif.w_o_flush = 1'b1;
      o_halted      = 1'b0;
    end
  end

  // FSM state, wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= 16'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_mem_timeout = tmo_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] lu_cnt_q, lu_cnt_d;

  // Event counters, wrapping modulo 2^32
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, pif.f_o_stall};
    flush_cnt_d = flush_cnt_q + {31'd0, w_redir_take};
    lu_cnt_d    = lu_cnt_q + {31'd0, w_lu_take};
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
      lu_cnt_q    <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
  assign o_lu_cnt    = lu_cnt_q;
`else
  assign o_stall_cnt = 32'd0;
  assign o_flush_cnt = 32'd0;
  assign o_lu_cnt    = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Brief    : Directed self-checking bench for pipe_ctrl (MEM_TIMEOUT = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam int C_PERF = 1;
`else
  localparam int C_PERF = 0;
`endif

  // control vector order: {f_st, d_st, e_st, m_st, d_fl, e_fl, w_fl}
  localparam logic [6:0] C_IDLE   = 7'b0000_000;
  localparam logic [6:0] C_RST    = 7'b0000_111;
  localparam logic [6:0] C_LU     = 7'b1100_010;
  localparam logic [6:0] C_REDIR  = 7'b0000_110;
  localparam logic [6:0] C_FREEZE = 7'b1111_001;

  logic        clk = 1'b0;
  logic        rst;
  logic        halted;
  logic        mem_tmo;
  logic [31:0] stall_cnt, flush_cnt, lu_cnt;
  int          n_total = 0;
  int          n_bad   = 0;

  pipe_ctrl_if pif ();

  pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .pif           (pif),
    .o_halted      (halted),
    .o_mem_timeout (mem_tmo),
    .o_stall_cnt   (stall_cnt),
    .o_flush_cnt   (flush_cnt),
    .o_lu_cnt      (lu_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl_vec();
    return {pif.f_o_stall, pif.d_o_stall, pif.e_o_stall, pif.m_o_stall,
            pif.d_o_flush, pif.e_o_flush, pif.w_o_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // advance one edge, then settle inputs away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pif.d_i_rs1 = 5'd0; pif.d_i_rs2 = 5'd0;
    pif.d_i_rs1_used = 1'b0; pif.d_i_rs2_used = 1'b0;
    pif.e_i_rd = 5'd0; pif.e_i_rd_wen = 1'b0; pif.e_i_is_load = 1'b0;
    pif.e_i_redirect = 1'b0; pif.m_i_req = 1'b0; pif.m_i_ready = 1'b0;
    pif.w_i_halt = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
    pif.e_i_is_load = 1'b1; pif.e_i_rd_wen = 1'b1; pif.e_i_rd = rd;
    pif.d_i_rs1 = rs1; pif.d_i_rs1_used = u1;
    pif.d_i_rs2 = rs2; pif.d_i_rs2_used = u2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("rst_ctl", 32'(ctl_vec()), 32'(C_RST));
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    chk("rst_ctl_init", 32'(ctl_vec()), 32'(C_RST));
    chk("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_tmo", 32'(mem_tmo), 32'd0);
    chk("reset_stallcnt", stall_cnt, 32'd0);
    chk("idle_ctl", 32'(ctl_vec()), 32'(C_IDLE));

    // load x5 ; add x6,x5,x1
    set_load(5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
    #1 chk("lu_rs1", 32'(ctl_vec()), 32'(C_LU));
    tick();
    idle_inputs();
    #1 chk("lu_after", 32'(ctl_vec()), 32'(C_IDLE));
    chk("lu_cnt1", lu_cnt, 32'(C_PERF * 1));

    // load to x0, and an unused source: no hazard
    set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1 chk("lu_x0", 32'(ctl_vec()), 32'(C_IDLE));
    set_load(5'd5, 5'd5, 1'b0, 5'd1, 1'b1);
    #1 chk("lu_unused", 32'(ctl_vec()), 32'(C_IDLE));
    set_load(5'd5, 5'd2, 1'b1, 5'd5, 1'b1);
    pif.e_i_rd_wen = 1'b0;
    #1 chk("lu_nowen", 32'(ctl_vec()), 32'(C_IDLE));
    pif.e_i_rd_wen = 1'b1;
    #1 chk("lu_rs2", 32'(ctl_vec()), 32'(C_LU));
    tick();

    // redirect together with a load-use hazard
    set_load(5'd7, 5'd7, 1'b1, 5'd7, 1'b1);
    pif.e_i_redirect = 1'b1;
    #1 chk("redir_ctl", 32'(ctl_vec()), 32'(C_REDIR));
    tick();
    idle_inputs();
    #1 chk("flush_cnt1", flush_cnt, 32'(C_PERF * 1));
    chk("lu_cnt2", lu_cnt, 32'(C_PERF * 2));

    // memory access with three wait cycles
    do_reset();
    chk("cnt_cleared", lu_cnt, 32'd0);
    pif.m_i_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("memwait_%0d", i), 32'(ctl_vec()), 32'(C_FREEZE));
      tick();
    end
    pif.m_i_ready = 1'b1;
    #1 chk("mem_ready", 32'(ctl_vec()), 32'(C_IDLE));
    tick();
    idle_inputs();
    #1 chk("mem_stallcnt", stall_cnt, 32'(C_PERF * 3));
    chk("mem_run", 32'(ctl_vec()), 32'(C_IDLE));

    // zero-wait access, then a wait ending with a redirect
    pif.m_i_req = 1'b1; pif.m_i_ready = 1'b1;
    #1 chk("mem_nowait", 32'(ctl_vec()), 32'(C_IDLE));
    tick();
    pif.m_i_ready = 1'b0;
    tick();
    pif.m_i_ready = 1'b1; pif.e_i_redirect = 1'b1;
    #1 chk("mem_ready_redir", 32'(ctl_vec()), 32'(C_REDIR));
    tick();
    idle_inputs();
    #1 chk("mem_redir_run", 32'(ctl_vec()), 32'(C_IDLE));

    // watchdog with MEM_TIMEOUT = 4 and no ready
    do_reset();
    pif.m_i_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("tmo_early", 32'(mem_tmo), 32'd0);
    begin : tmo_wait
      int n = 0;
      while (!mem_tmo && n < 20) begin tick(); n++; end
      chk("tmo_latency", 32'(n), 32'd1);
    end
    chk("tmo_halted", 32'(halted), 32'd1);
    pif.m_i_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("tmo_sticky", 32'(mem_tmo), 32'd1);
    chk("tmo_freeze", 32'(ctl_vec()), 32'(C_FREEZE));
    do_reset();
    chk("tmo_clear", 32'(mem_tmo), 32'd0);
    chk("tmo_unhalt", 32'(halted), 32'd0);

    // halt and mem-wait together: halt wins
    pif.w_i_halt = 1'b1; pif.m_i_req = 1'b1;
    #1 chk("halt_ctl", 32'(ctl_vec()), 32'(C_FREEZE));
    tick();
    idle_inputs();
    pif.m_i_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 chk($sformatf("halt_hold_%0d", i), 32'(ctl_vec()), 32'(C_FREEZE));
      tick();
    end
    chk("halt_state", 32'(halted), 32'd1);
    chk("halt_stallcnt", stall_cnt, 32'(C_PERF * 11));
    do_reset();
    chk("halt_rst_ctl", 32'(ctl_vec()), 32'(C_IDLE));
    chk("halt_rst_state", 32'(halted), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
